// File: rtl/alu_core.sv
// alu_core: registered DATA_W-bit add/subtract ALU with carry (C) and overflow (V) flags.
// Defining ALU_ZN_FLAGS_EN adds registered zero (Z) and negative (N) flag outputs.
module alu_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] alu_srcA_i,
    input  logic [DATA_W+1:0] alu_srcB_i,
    input  logic [1:0]        alu_ctrl_i,
    output logic [DATA_W-1:0] alu_result_o,
    output logic              alu_C_flag_o,
`ifdef ALU_ZN_FLAGS_EN
    output logic              alu_V_flag_o,
    output logic              alu_Z_flag_o,
    output logic              alu_N_flag_o
`else
    output logic              alu_V_flag_o
`endif
);
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] bx;
    logic [DATA_W:0]   s;
    logic              v;
    logic              c;
    logic              unused_tags;

    // Subtraction is a + ~b + 1, so cout=1 means no borrow.
    assign a           = alu_srcA_i[DATA_W-1:0];
    assign bx          = alu_ctrl_i[0] ? ~alu_srcB_i[DATA_W-1:0] : alu_srcB_i[DATA_W-1:0];
    assign s           = {1'b0, a} + {1'b0, bx} + {{DATA_W{1'b0}}, alu_ctrl_i[0]};
    assign v           = (a[DATA_W-1] == bx[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    assign c           = s[DATA_W] ^ alu_ctrl_i[1];
    assign unused_tags = ^{alu_srcA_i[DATA_W+1:DATA_W], alu_srcB_i[DATA_W+1:DATA_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_o <= '0;
            alu_C_flag_o <= 1'b0;
            alu_V_flag_o <= 1'b0;
`ifdef ALU_ZN_FLAGS_EN
            alu_Z_flag_o <= 1'b0;
            alu_N_flag_o <= 1'b0;
`endif
        end else begin
            alu_result_o <= s[DATA_W-1:0];
            alu_C_flag_o <= c;
            alu_V_flag_o <= v;
`ifdef ALU_ZN_FLAGS_EN
            alu_Z_flag_o <= (s[DATA_W-1:0] == '0);
            alu_N_flag_o <= s[DATA_W-1];
`endif
        end
    end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed spec vectors plus randomized back-to-back traffic checked
// against an integer-arithmetic reference model.
module tb_alu_core;
    logic        clk;
    logic        rst_n;
    logic [33:0] src_a;
    logic [33:0] src_b;
    logic [1:0]  ctrl;
    logic [31:0] result;
    logic        c_flag;
    logic        v_flag;
`ifdef ALU_ZN_FLAGS_EN
    logic        z_flag;
    logic        n_flag;
`endif
    int n_cmp = 0;
    int n_err = 0;

    alu_core #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_srcA_i   (src_a),
        .alu_srcB_i   (src_b),
        .alu_ctrl_i   (ctrl),
        .alu_result_o (result),
        .alu_C_flag_o (c_flag),
`ifdef ALU_ZN_FLAGS_EN
        .alu_V_flag_o (v_flag),
        .alu_Z_flag_o (z_flag),
        .alu_N_flag_o (n_flag)
`else
        .alu_V_flag_o (v_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [33:0] a;
        logic [33:0] b;
        logic [1:0]  ctl;
        logic [31:0] r;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[9] = '{
        '{34'h3_FFFFFFFF, 34'h3_FFFFFFFF, 2'b00, 32'hFFFFFFFE, 1'b1, 1'b0},
        '{34'h0_7FFFFFFF, 34'h0_7FFFFFFF, 2'b00, 32'hFFFFFFFE, 1'b0, 1'b1},
        '{34'h3_80000000, 34'h3_80000000, 2'b00, 32'h00000000, 1'b1, 1'b1},
        '{34'h3_FFFFFFFF, 34'h3_FFFFFFFF, 2'b10, 32'hFFFFFFFE, 1'b0, 1'b0},
        '{34'h0_7FFFFFFF, 34'h1_7FFFFFFF, 2'b10, 32'hFFFFFFFE, 1'b1, 1'b1},
        '{34'h3_80000000, 34'h3_80000000, 2'b10, 32'h00000000, 1'b0, 1'b1},
        '{34'h0_00000005, 34'h0_00000003, 2'b01, 32'h00000002, 1'b1, 1'b0},
        '{34'h0_80000000, 34'h0_00000001, 2'b01, 32'h7FFFFFFF, 1'b1, 1'b1},
        '{34'h0_00000003, 34'h0_00000005, 2'b11, 32'hFFFFFFFE, 1'b1, 1'b0}
    };

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sums for carry, signed sums for overflow; returns {c, v, r}.
    function automatic logic [33:0] model(input logic [33:0] a, input logic [33:0] b, input logic [1:0] ctl);
        longint ua = longint'(a[31:0]);
        longint ub = longint'(b[31:0]);
        longint sa = longint'($signed(a[31:0]));
        longint sb = longint'($signed(b[31:0]));
        longint sum = ctl[0] ? ua - ub : ua + ub;
        longint sres = ctl[0] ? sa - sb : sa + sb;
        logic cout = ctl[0] ? (ua >= ub) : (sum >= 64'sh1_0000_0000);
        logic ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        logic [31:0] r = sum[31:0];
        return {cout ^ ctl[1], ov, r};
    endfunction

    task automatic check_out(input string tag, input logic [33:0] exp);
        check({tag, ".r"}, 64'(result), 64'(exp[31:0]));
        check({tag, ".c"}, 64'(c_flag), 64'(exp[33]));
        check({tag, ".v"}, 64'(v_flag), 64'(exp[32]));
`ifdef ALU_ZN_FLAGS_EN
        check({tag, ".z"}, 64'(z_flag), 64'(exp[31:0] == 32'h0));
        check({tag, ".n"}, 64'(n_flag), 64'(exp[31]));
`endif
    endtask

    initial begin
        logic [33:0] prev;
        logic [33:0] exp;
        rst_n = 1'b1;
        src_a = 34'h0;
        src_b = 34'h0;
        ctrl  = 2'b00;
        #1 rst_n = 1'b0;
        #1 check_out("reset0", 34'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        prev = 34'h0;
        // Directed vectors, each with a mid-cycle input change that must not disturb outputs.
        foreach (vecs[i]) begin
            @(posedge clk);
            #2;
            src_a = vecs[i].a;
            src_b = vecs[i].b;
            ctrl  = vecs[i].ctl;
            #1 check_out($sformatf("hold%0d", i), prev);
            @(posedge clk);
            #1 check_out($sformatf("vec%0d", i), {vecs[i].c, vecs[i].v, vecs[i].r});
            check($sformatf("model%0d", i), 64'(model(vecs[i].a, vecs[i].b, vecs[i].ctl)),
                  64'({vecs[i].c, vecs[i].v, vecs[i].r}));
            prev = {vecs[i].c, vecs[i].v, vecs[i].r};
        end
        // Asynchronous reset in mid-cycle, then recovery on the next edge.
        #2 rst_n = 1'b0;
        #1 check_out("reset_mid", 34'h0);
        @(posedge clk);
        #1 check_out("reset_held", 34'h0);
        src_a = 34'h2_12345678;
        src_b = 34'h1_0FEDCBA9;
        ctrl  = 2'b01;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 check_out("reset_rel", model(src_a, src_b, ctrl));
        // Back-to-back random traffic, one result per cycle, with corner operands mixed in.
        exp = model(src_a, src_b, ctrl);
        for (int i = 0; i < 300; i++) begin
            src_a = {$urandom_range(3, 0), $urandom()};
            src_b = {$urandom_range(3, 0), $urandom()};
            if ($urandom_range(7, 0) == 0) src_a[31:0] = 32'h80000000;
            if ($urandom_range(7, 0) == 0) src_b[31:0] = 32'h7FFFFFFF;
            if ($urandom_range(9, 0) == 0) src_b[31:0] = src_a[31:0];
            ctrl = 2'($urandom_range(3, 0));
            exp = model(src_a, src_b, ctrl);
            @(posedge clk);
            #1 check_out($sformatf("rnd%0d", i), exp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
